// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline sequencer bus: stage hazard/control-transfer status in, register
// enables, flushes, redirect and performance counters out.
interface pipeline_hazard_ctrl_if;
    logic [5:0]  rsID;
    logic [5:0]  rtID;
    logic        rtUsedID;
    logic        MemReadEX;
    logic [5:0]  rdEX;
    logic        JumpMEM;
    logic        JumpMemMEM;
    logic        BranchZeroMEM;
    logic        BranchNegMEM;
    logic        zeroMEM;
    logic        negMEM;
    logic        MemReadMEM;
    logic        MemWriteMEM;
    logic        dmem_ready;

    logic        pcEn;
    logic        ifidEn;
    logic        idexEn;
    logic        exmemEn;
    logic        memwbEn;
    logic        ifidFlush;
    logic        idexFlush;
    logic        exmemFlush;
    logic        pcRedirect;
    logic        memErr;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    modport master (
        output rsID, rtID, rtUsedID, MemReadEX, rdEX,
               JumpMEM, JumpMemMEM, BranchZeroMEM, BranchNegMEM, zeroMEM, negMEM,
               MemReadMEM, MemWriteMEM, dmem_ready,
        input  pcEn, ifidEn, idexEn, exmemEn, memwbEn,
               ifidFlush, idexFlush, exmemFlush, pcRedirect,
               memErr, stallCount, flushCount
    );

    modport slave (
        input  rsID, rtID, rtUsedID, MemReadEX, rdEX,
               JumpMEM, JumpMemMEM, BranchZeroMEM, BranchNegMEM, zeroMEM, negMEM,
               MemReadMEM, MemWriteMEM, dmem_ready,
        output pcEn, ifidEn, idexEn, exmemEn, memwbEn,
               ifidFlush, idexFlush, exmemFlush, pcRedirect,
               memErr, stallCount, flushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use bubbles, MEM-stage redirects,
// data-memory freeze with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic {RUN, LOAD_STALL} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [2:0]  BUB_INIT     = 3'(LOAD_USE_STALL - 1);

    state_t      state;
    logic [2:0]  bubCnt;
    logic [15:0] waitCnt;
    logic        memErrQ;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    logic taken;
    logic memReq;
    logic timeout;
    logic memBusy;
    logic hazard;
    logic bubble;
    logic stallCyc;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign taken   = bus.JumpMEM | bus.JumpMemMEM
                   | (bus.BranchZeroMEM & bus.zeroMEM)
                   | (bus.BranchNegMEM & bus.negMEM);
    assign memReq  = bus.MemReadMEM | bus.MemWriteMEM | bus.JumpMemMEM;
    assign timeout = (waitCnt == TIMEOUT_LAST);
    assign memBusy = memReq & ~bus.dmem_ready & ~timeout;
    assign hazard  = bus.MemReadEX & (bus.rdEX != 6'd0)
                   & ((bus.rdEX == bus.rsID) | (bus.rtUsedID & (bus.rdEX == bus.rtID)));
    assign bubble  = (state == LOAD_STALL) | hazard;
    // PC holds either for a memory freeze or for a load-use bubble not overridden by a redirect
    assign stallCyc = memBusy | (~taken & bubble);

    always_comb begin
        bus.pcEn       = 1'b0;
        bus.ifidEn     = 1'b0;
        bus.idexEn     = 1'b0;
        bus.exmemEn    = 1'b0;
        bus.memwbEn    = 1'b0;
        bus.ifidFlush  = 1'b0;
        bus.idexFlush  = 1'b0;
        bus.exmemFlush = 1'b0;
        bus.pcRedirect = 1'b0;
        if (rst_n && !memBusy) begin
            bus.idexEn  = 1'b1;
            bus.exmemEn = 1'b1;
            bus.memwbEn = 1'b1;
            if (taken) begin
                bus.pcEn       = 1'b1;
                bus.ifidEn     = 1'b1;
                bus.ifidFlush  = 1'b1;
                bus.idexFlush  = 1'b1;
                bus.exmemFlush = 1'b1;
                bus.pcRedirect = 1'b1;
            end else if (bubble) begin
                bus.idexFlush = 1'b1;
            end else begin
                bus.pcEn   = 1'b1;
                bus.ifidEn = 1'b1;
            end
        end
    end

    assign bus.memErr     = memErrQ;
    assign bus.stallCount = stallCnt;
    assign bus.flushCount = flushCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            bubCnt   <= 3'd0;
            waitCnt  <= 16'd0;
            memErrQ  <= 1'b0;
            stallCnt <= 32'd0;
            flushCnt <= 32'd0;
        end else begin
            if (stallCyc) begin
                stallCnt <= satInc(stallCnt);
            end
            if (memBusy) begin
                waitCnt <= waitCnt + 16'd1;
            end else begin
                waitCnt <= 16'd0;
                // A request still unanswered here was released by the timeout
                if (memReq && !bus.dmem_ready) begin
                    memErrQ <= 1'b1;
                end
                if (taken) begin
                    flushCnt <= satInc(flushCnt);
                    state    <= RUN;
                    bubCnt   <= 3'd0;
                end else if (state == LOAD_STALL) begin
                    bubCnt <= bubCnt - 3'd1;
                    if (bubCnt == 3'd1) begin
                        state <= RUN;
                    end
                end else if (hazard && (LOAD_USE_STALL > 1)) begin
                    state  <= LOAD_STALL;
                    bubCnt <= BUB_INIT;
                end
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline sequencer for the 5-stage core: drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, resolves control transfers (jumps, memory-indirect jumps, zero/negative branches) carried in the MEM stage, and freezes the pipe while data memory is busy. It also keeps saturating stall and flush performance counters.

## Interface
- LOAD_USE_STALL, 1: bubble cycles inserted per load-use hazard; legal range 1..7.
- MEM_TIMEOUT, 255: consecutive busy-memory cycles before a forced release; legal range 1..65535.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- rsID, rtID  input  6 each  source registers of the instruction in ID.
- rtUsedID  input  1  ID instruction reads rt.
- MemReadEX  input  1  EX instruction is a load.
- rdEX  input  6  destination register of the EX instruction.
- JumpMEM, JumpMemMEM, BranchZeroMEM, BranchNegMEM  input  1 each  control-transfer type of the MEM instruction.
- zeroMEM, negMEM  input  1 each  ALU flags latched with the MEM instruction.
- MemReadMEM, MemWriteMEM  input  1 each  MEM instruction accesses data memory.
- dmem_ready  input  1  data memory completes the current access this cycle.
- pcEn, ifidEn, idexEn, exmemEn, memwbEn  output  1 each  register update enables.
- ifidFlush, idexFlush, exmemFlush  output  1 each  load a bubble (all-zero controls) on the next edge.
- pcRedirect  output  1  PC takes the MEM-stage target on the next edge.
- memErr  output  1  sticky memory-timeout flag.
- stallCount  output  32  cycles with pcEn=0.
- flushCount  output  32  number of redirects.

## Operation
- taken = JumpMEM | JumpMemMEM | (BranchZeroMEM & zeroMEM) | (BranchNegMEM & negMEM).
- memBusy = (MemReadMEM | MemWriteMEM | JumpMemMEM) & ~dmem_ready & ~timeout, where timeout = (waitCnt == MEM_TIMEOUT-1).
- hazard = MemReadEX & (rdEX != 0) & ((rdEX == rsID) | (rtUsedID & rdEX == rtID)).
- States: RUN and LOAD_STALL, with a 3-bit bubble counter bubCnt.
- Priority, highest first: memBusy, taken, LOAD_STALL continuation, hazard.
- memBusy: all five enables 0 and all flushes 0. State, bubCnt and the perf counters other than stallCount are frozen. waitCnt increments.
- Timeout: when waitCnt reaches MEM_TIMEOUT-1, memBusy is forced low for that cycle and memErr sets. memErr clears only on reset.
- taken without memBusy: all enables 1. ifidFlush, idexFlush, exmemFlush and pcRedirect are 1, and flushCount increments. The state goes to RUN and bubCnt clears, so a pending load-use stall is discarded.
- hazard in RUN: pcEn=0, ifidEn=0 and idexFlush=1; the other enables are 1. If LOAD_USE_STALL>1, go to LOAD_STALL with bubCnt=LOAD_USE_STALL-1.
- LOAD_STALL: same outputs as a hazard cycle. bubCnt decrements each unfrozen cycle, and the state returns to RUN after the cycle in which bubCnt==1.
- Otherwise, all enables are 1 and all flushes are 0.
- waitCnt clears on every cycle in which memBusy is 0.
- Both perf counters saturate at 0xFFFFFFFF.

## Timing
- All control outputs are combinational (Mealy) from the current state and inputs. The registered state changes only on the rising edge of clk.
- While rst_n=0, and on the first cycle after release, the registered state is: state RUN, bubCnt=0, waitCnt=0, memErr=0, stallCount=0, flushCount=0.
- While rst_n=0, outputs are forced: all enables 0, all flushes 0, pcRedirect 0.
- An asserted rst_n mid-stall or mid-wait aborts immediately, with no residual bubble.
- Load-use penalty is exactly LOAD_USE_STALL cycles; redirect penalty is 3 flushed slots; memory stalls last until dmem_ready, or at most MEM_TIMEOUT cycles.
- taken and hazard in the same cycle: the redirect wins and no bubble is inserted.
- A memory stall during LOAD_STALL freezes bubCnt; the stall resumes afterwards.
- rdEX=0 never causes a hazard.

## Test plan
- Load-use stall: MemReadEX=1, rdEX=5, rsID=5, LOAD_USE_STALL=1 -> one cycle with pcEn=0, ifidEn=0, idexFlush=1; next cycle all enables 1; stallCount=1.
- Redirect over hazard: BranchZeroMEM=1, zeroMEM=1 with a simultaneous hazard -> pcRedirect=1 and the three flushes=1 for one cycle, no bubble; flushCount=1.
- Untaken branch: BranchNegMEM=1, negMEM=0 -> no redirect, no flushes.
- Memory stall then redirect: MemReadMEM=1, dmem_ready low for 4 cycles -> all enables 0 for 4 cycles, stallCount=4. Then JumpMemMEM=1 with dmem_ready=1 -> redirect in that cycle.
- Timeout: MEM_TIMEOUT=8, dmem_ready held 0 -> the pipe releases on cycle 8 and memErr=1 from then on. Also check that rst_n low mid-LOAD_STALL (LOAD_USE_STALL=3) gives all outputs 0 and no bubble after release.
